// File: rtl/moving_average.sv
// Boxcar moving-average filter with a run-time selectable power-of-two window.
// Mean is the running window sum arithmetically shifted by log2(N), registered one cycle after acceptance.
module moving_average #(
  parameter int MAX_LOG2 = 6,
  parameter int DATA_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Input,
  input  logic              InputValid,
  input  logic [2:0]        WindowLog2,
  output logic [DATA_W-1:0] Output,
  output logic              OutputValid,
  output logic              Filled
);

  localparam int DEPTH = 2 ** MAX_LOG2;
  localparam int ACC_W = DATA_W + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;

  localparam logic [0:0]          ST_FILL = 1'b0;
  localparam logic [0:0]          ST_RUN  = 1'b1;
  localparam logic [2:0]          WIN_MAX = 3'(MAX_LOG2);
  localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MAX_LOG2-1:0] PTR_ONE = {{(MAX_LOG2-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [0:0]          state_q, state_d;
  logic [2:0]          win_q, win_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAX_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                ovld_q;
  logic                filled_q;

  logic [2:0]          win_in_s;
  logic [CNT_W-1:0]    n_s;
  logic [MAX_LOG2-1:0] rd_ptr_s;
  logic [ACC_W-1:0]    in_ext_s;
  logic [ACC_W-1:0]    old_ext_s;
  logic [DATA_W-1:0]   mean_s;

  assign win_in_s  = (WindowLog2 > WIN_MAX) ? WIN_MAX : WindowLog2;
  assign n_s       = CNT_ONE << win_q;
  // For N = 2^MAX_LOG2 the low bits of n_s are zero, so the oldest entry is the one about to be overwritten.
  assign rd_ptr_s  = wr_ptr_q - n_s[MAX_LOG2-1:0];
  assign in_ext_s  = {{MAX_LOG2{Input[DATA_W-1]}}, Input};
  assign old_ext_s = {{MAX_LOG2{mem_q[rd_ptr_s][DATA_W-1]}}, mem_q[rd_ptr_s]};
  assign mean_s    = DATA_W'($signed(acc_q) >>> win_q);

  // Next-state logic for the fill/run window tracker.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pend_d   = 1'b0;
    wr_ptr_d = InputValid ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    if (win_in_s != win_q) begin
      win_d   = win_in_s;
      acc_d   = InputValid ? in_ext_s : {ACC_W{1'b0}};
      cnt_d   = {{(CNT_W-1){1'b0}}, InputValid};
      pend_d  = InputValid && (win_in_s == 3'd0);
      state_d = pend_d ? ST_RUN : ST_FILL;
    end else if (InputValid) begin
      case (state_q)
        ST_FILL: begin
          acc_d = acc_q + in_ext_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == n_s) begin
            state_d = ST_RUN;
            pend_d  = 1'b1;
          end else begin
            state_d = ST_FILL;
            pend_d  = 1'b0;
          end
        end
        ST_RUN: begin
          acc_d  = acc_q + in_ext_s - old_ext_s;
          pend_d = 1'b1;
        end
        default: begin
          state_d = ST_FILL;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output register tracks the mean only when a result is due, otherwise holds.
  always_comb begin
    if (pend_q) begin
      out_d = mean_s;
    end else begin
      out_d = out_q;
    end
  end

  // Sample buffer: deliberately unreset, stale entries are never subtracted.
  always_ff @(posedge Clk) begin
    if (InputValid) begin
      mem_q[wr_ptr_q] <= Input;
    end
  end

  // Window state, accumulator and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_FILL;
      win_q    <= 3'd0;
      acc_q    <= {ACC_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      wr_ptr_q <= {MAX_LOG2{1'b0}};
      pend_q   <= 1'b0;
      out_q    <= {DATA_W{1'b0}};
      ovld_q   <= 1'b0;
      filled_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      pend_q   <= pend_d;
      out_q    <= out_d;
      ovld_q   <= pend_q;
      filled_q <= (state_q == ST_RUN);
    end
  end

  assign Output      = out_q;
  assign OutputValid = ovld_q;
  assign Filled      = filled_q;

endmodule
